// File: rtl/display_scheduler_if.sv
// -----------------------------------------------------------------------------
// display_scheduler_if
// Purpose : Bundles the source-request, alert and display-side signals of the
//           display scheduler so they travel as one port.
// Signals :
//   src_valid    N_SRC     level, bit i = source i has a value to show
//   src_value    12*N_SRC  packed source values, source i at [12*i+11:12*i]
//   src_ack      N_SRC     one-cycle pulse when source i is snapshotted
//   alert_req    1         pulse, pre-empt rotation with alert_value
//   alert_value  12        value shown during an alert
//   freeze       1         level, pauses the slot timer
//   value        12        value to the 7-segment display block
//   blank        1         high = nothing to show
//   src_id       SEL_W     index of the source currently shown
//   alert_active 1         high while the alert value is displayed
// Modports: master = producers/display side, slave = the scheduler.
// -----------------------------------------------------------------------------
interface display_scheduler_if #(
   parameter int N_SRC = 4,
   parameter int SEL_W = 2
);
   logic [N_SRC-1:0]    src_valid;
   logic [12*N_SRC-1:0] src_value;
   logic [N_SRC-1:0]    src_ack;
   logic                alert_req;
   logic [11:0]         alert_value;
   logic                freeze;
   logic [11:0]         value;
   logic                blank;
   logic [SEL_W-1:0]    src_id;
   logic                alert_active;

   modport master (
      output src_valid, src_value, alert_req, alert_value, freeze,
      input  src_ack, value, blank, src_id, alert_active
   );

   modport slave (
      input  src_valid, src_value, alert_req, alert_value, freeze,
      output src_ack, value, blank, src_id, alert_active
   );
endinterface

// File: rtl/display_scheduler.sv
// -----------------------------------------------------------------------------
// display_scheduler
// Purpose : Time-shares a 4-digit 7-segment display between N_SRC producers.
//           Valid sources are shown round-robin for HOLD_CYCLES each; an alert
//           request pre-empts rotation for ALERT_CYCLES. Every shown source is
//           acknowledged when its value is snapshotted.
// Ports   :
//   clk    input   system clock
//   rst_n  input   asynchronous active-low reset
//   bus    slave   display_scheduler_if (requests, alert, display outputs)
// All outputs are registered.
// -----------------------------------------------------------------------------
module display_scheduler #(
   parameter int N_SRC        = 4,
   parameter int HOLD_CYCLES  = 100_000_000,
   parameter int ALERT_CYCLES = 200_000_000,
   parameter int CNT_W        = 28,
   parameter int SEL_W        = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   display_scheduler_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, SHOW, ALERT} state_t;

   // One extra bit so last + (gi+1) never overflows before the wrap.
   localparam int                SUM_W      = SEL_W + 1;
   localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  ALERT_LAST = CNT_W'(ALERT_CYCLES - 1);
   localparam logic [SEL_W-1:0]  LAST_RST   = SEL_W'(N_SRC - 1);

   state_t             r_state, w_state_next;
   logic [SEL_W-1:0]   r_last, w_last_next;
   logic [CNT_W-1:0]   r_slot_cnt, w_slot_cnt_next;
   logic [CNT_W-1:0]   r_alert_cnt, w_alert_cnt_next;
   logic [11:0]        r_value, w_value_next;
   logic               r_blank, w_blank_next;
   logic [SEL_W-1:0]   r_src_id, w_src_id_next;
   logic [N_SRC-1:0]   r_ack, w_ack_next;
   logic               r_alert_active, w_alert_active_next;

   logic [11:0]        w_src_val [N_SRC];
   logic [SEL_W-1:0]   w_cand_idx [N_SRC];
   logic [N_SRC-1:0]   w_cand_ok;
   logic               w_pick_found;
   logic [SEL_W-1:0]   w_pick_idx;
   logic               w_do_pick;

   // Candidate gi is source (last + gi + 1) mod N_SRC; candidate N_SRC-1
   // is last itself, so a lone valid source is re-picked every slot.
   genvar gi;
   generate
      for (gi = 0; gi < N_SRC; gi++) begin : g_cand
         logic [SUM_W-1:0] w_sum;
         assign w_src_val[gi]  = bus.src_value[12*gi +: 12];
         assign w_sum          = {1'b0, r_last} + SUM_W'(gi + 1);
         assign w_cand_idx[gi] = (w_sum >= SUM_W'(N_SRC)) ?
                                 SEL_W'(w_sum - SUM_W'(N_SRC)) : SEL_W'(w_sum);
         assign w_cand_ok[gi]  = bus.src_valid[w_cand_idx[gi]];
      end
   endgenerate

   // Lowest candidate position wins: scan downwards so the last hit sticks.
   always_comb begin
      w_pick_found = 1'b0;
      w_pick_idx   = '0;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         if (w_cand_ok[k]) begin
            w_pick_found = 1'b1;
            w_pick_idx   = w_cand_idx[k];
         end
      end
   end

   always_comb begin
      w_state_next        = r_state;
      w_last_next         = r_last;
      w_slot_cnt_next     = r_slot_cnt;
      w_alert_cnt_next    = r_alert_cnt;
      w_value_next        = r_value;
      w_blank_next        = r_blank;
      w_src_id_next       = r_src_id;
      w_ack_next          = '0;
      w_alert_active_next = r_alert_active;
      w_do_pick           = 1'b0;

      if (bus.alert_req) begin
         // Alert beats any slot-end pick: no ack, pointer and src_id kept.
         w_state_next        = ALERT;
         w_value_next        = bus.alert_value;
         w_alert_active_next = 1'b1;
         w_blank_next        = 1'b0;
         w_alert_cnt_next    = '0;
      end else begin
         case (r_state)
            IDLE: w_do_pick = 1'b1;
            SHOW: begin
               // Freeze on the terminal count extends the slot.
               if (!bus.freeze) begin
                  if (r_slot_cnt == HOLD_LAST) begin
                     w_do_pick = 1'b1;
                  end else begin
                     w_slot_cnt_next = r_slot_cnt + CNT_W'(1);
                  end
               end
            end
            ALERT: begin
               if (r_alert_cnt == ALERT_LAST) begin
                  w_do_pick           = 1'b1;
                  w_alert_active_next = 1'b0;
               end else begin
                  w_alert_cnt_next = r_alert_cnt + CNT_W'(1);
               end
            end
            default: w_do_pick = 1'b1;
         endcase
      end

      if (w_do_pick) begin
         if (w_pick_found) begin
            w_value_next           = w_src_val[w_pick_idx];
            w_src_id_next          = w_pick_idx;
            w_last_next            = w_pick_idx;
            w_ack_next[w_pick_idx] = 1'b1;
            w_slot_cnt_next        = '0;
            w_blank_next           = 1'b0;
            w_state_next           = SHOW;
         end else begin
            w_value_next = '0;
            w_blank_next = 1'b1;
            w_state_next = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_last         <= LAST_RST;
         r_slot_cnt     <= '0;
         r_alert_cnt    <= '0;
         r_value        <= '0;
         r_blank        <= 1'b1;
         r_src_id       <= '0;
         r_ack          <= '0;
         r_alert_active <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_last         <= w_last_next;
         r_slot_cnt     <= w_slot_cnt_next;
         r_alert_cnt    <= w_alert_cnt_next;
         r_value        <= w_value_next;
         r_blank        <= w_blank_next;
         r_src_id       <= w_src_id_next;
         r_ack          <= w_ack_next;
         r_alert_active <= w_alert_active_next;
      end
   end

   assign bus.value        = r_value;
   assign bus.blank        = r_blank;
   assign bus.src_id       = r_src_id;
   assign bus.src_ack      = r_ack;
   assign bus.alert_active = r_alert_active;

endmodule

// File: tb/tb_display_scheduler.sv
// -----------------------------------------------------------------------------
// tb_display_scheduler
// Purpose : Self-checking bench for display_scheduler (N_SRC=4, HOLD=8,
//           ALERT=5): a table of directed vectors, hand-written reset
//           sequences, then randomized stimulus against a reference model.
// -----------------------------------------------------------------------------
module tb_display_scheduler;

   localparam int N_SRC = 4;
   localparam int HOLD  = 8;
   localparam int ALRT  = 5;
   localparam int CNT_W = 28;
   localparam int SEL_W = 2;

   localparam logic [47:0] P0 = {12'd0,   12'd4000, 12'd0,   12'd123};
   localparam logic [47:0] P1 = {12'd999, 12'd4000, 12'd0,   12'd123};
   localparam logic [47:0] P2 = {12'd42,  12'd4000, 12'd0,   12'd123};
   localparam logic [47:0] P3 = {12'd0,   12'd222,  12'd111, 12'd0};
   localparam logic [47:0] P4 = {12'd44,  12'd33,   12'd22,  12'd11};

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   display_scheduler_if #(.N_SRC(N_SRC), .SEL_W(SEL_W)) bus ();

   display_scheduler #(
      .N_SRC(N_SRC), .HOLD_CYCLES(HOLD), .ALERT_CYCLES(ALRT),
      .CNT_W(CNT_W), .SEL_W(SEL_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string nm, input logic [11:0] ev, input logic eb,
                        input logic [1:0] eid, input logic [3:0] eack, input logic ea);
      checks++;
      if (bus.value !== ev || bus.blank !== eb || bus.src_id !== eid ||
          bus.src_ack !== eack || bus.alert_active !== ea) begin
         failures++;
         $display("FAIL %s: got value=%0d blank=%b id=%0d ack=%b alert=%b, want value=%0d blank=%b id=%0d ack=%b alert=%b",
                  nm, bus.value, bus.blank, bus.src_id, bus.src_ack, bus.alert_active,
                  ev, eb, eid, eack, ea);
      end else begin
         $display("ok   %s: value=%0d blank=%b id=%0d ack=%b alert=%b",
                  nm, bus.value, bus.blank, bus.src_id, bus.src_ack, bus.alert_active);
      end
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      int          n;      // clock edges to apply
      logic [3:0]  valid;
      logic [47:0] vals;
      logic        areq;   // asserted for the first edge only
      logic [11:0] aval;
      logic        frz;
      logic [11:0] ev;
      logic        eb;
      logic [1:0]  eid;
      logic [3:0]  eack;
      logic        ea;
   } vec_t;

   vec_t tbl [37];

   // ---------------- reference model ----------------
   int          m_mode;   // 0 idle, 1 showing a source, 2 alert
   int          m_last;
   int          m_used;   // unfrozen cycles spent in current slot
   int          m_left;   // alert cycles remaining
   logic [11:0] e_val;
   logic        e_blank;
   int          e_id;
   logic [3:0]  e_ack;
   logic        e_alert;

   task automatic model_reset();
      m_mode = 0; m_last = N_SRC - 1; m_used = 0; m_left = 0;
      e_val = '0; e_blank = 1'b1; e_id = 0; e_ack = '0; e_alert = 1'b0;
   endtask

   task automatic model_pick();
      bit found = 0;
      for (int k = 1; k <= N_SRC; k++) begin
         int i;
         i = (m_last + k) % N_SRC;
         if (!found && bus.src_valid[i]) begin
            found = 1;
            e_val = bus.src_value[12*i +: 12];
            e_id = i; m_last = i; e_ack[i] = 1'b1;
            e_blank = 1'b0; m_mode = 1; m_used = 0;
         end
      end
      if (!found) begin
         e_blank = 1'b1; e_val = '0; m_mode = 0;
      end
   endtask

   task automatic model_step();
      e_ack = '0;
      if (bus.alert_req) begin
         m_mode = 2; m_left = ALRT;
         e_val = bus.alert_value; e_alert = 1'b1; e_blank = 1'b0;
      end else if (m_mode == 0) begin
         model_pick();
      end else if (m_mode == 1) begin
         if (!bus.freeze) begin
            m_used++;
            if (m_used == HOLD) model_pick();
         end
      end else begin
         m_left--;
         if (m_left == 0) begin
            e_alert = 1'b0;
            model_pick();
         end
      end
   endtask

   initial begin
      // Directed vectors (expected values after the n-th edge).
      tbl[0]  = '{2,  4'b0000, P0, 1'b0, 12'd0,    1'b0, 12'd0,    1'b1, 2'd0, 4'b0000, 1'b0};
      tbl[1]  = '{1,  4'b0101, P0, 1'b0, 12'd0,    1'b0, 12'd123,  1'b0, 2'd0, 4'b0001, 1'b0};
      tbl[2]  = '{7,  4'b0101, P0, 1'b0, 12'd0,    1'b0, 12'd123,  1'b0, 2'd0, 4'b0000, 1'b0};
      tbl[3]  = '{1,  4'b0101, P0, 1'b0, 12'd0,    1'b0, 12'd4000, 1'b0, 2'd2, 4'b0100, 1'b0};
      tbl[4]  = '{8,  4'b0101, P0, 1'b0, 12'd0,    1'b0, 12'd123,  1'b0, 2'd0, 4'b0001, 1'b0};
      tbl[5]  = '{8,  4'b1000, P1, 1'b0, 12'd0,    1'b0, 12'd999,  1'b0, 2'd3, 4'b1000, 1'b0};
      tbl[6]  = '{3,  4'b1000, P2, 1'b0, 12'd0,    1'b0, 12'd999,  1'b0, 2'd3, 4'b0000, 1'b0};
      tbl[7]  = '{5,  4'b1000, P2, 1'b0, 12'd0,    1'b0, 12'd42,   1'b0, 2'd3, 4'b1000, 1'b0};
      tbl[8]  = '{8,  4'b1000, P2, 1'b0, 12'd0,    1'b0, 12'd42,   1'b0, 2'd3, 4'b1000, 1'b0};
      tbl[9]  = '{8,  4'b0110, P3, 1'b0, 12'd0,    1'b0, 12'd111,  1'b0, 2'd1, 4'b0010, 1'b0};
      tbl[10] = '{2,  4'b0110, P3, 1'b0, 12'd0,    1'b0, 12'd111,  1'b0, 2'd1, 4'b0000, 1'b0};
      tbl[11] = '{1,  4'b0110, P3, 1'b1, 12'd3210, 1'b0, 12'd3210, 1'b0, 2'd1, 4'b0000, 1'b1};
      tbl[12] = '{4,  4'b0110, P3, 1'b0, 12'd0,    1'b0, 12'd3210, 1'b0, 2'd1, 4'b0000, 1'b1};
      tbl[13] = '{1,  4'b0110, P3, 1'b0, 12'd0,    1'b0, 12'd222,  1'b0, 2'd2, 4'b0100, 1'b0};
      tbl[14] = '{3,  4'b0110, P3, 1'b0, 12'd0,    1'b0, 12'd222,  1'b0, 2'd2, 4'b0000, 1'b0};
      tbl[15] = '{20, 4'b0110, P3, 1'b0, 12'd0,    1'b1, 12'd222,  1'b0, 2'd2, 4'b0000, 1'b0};
      tbl[16] = '{4,  4'b0110, P3, 1'b0, 12'd0,    1'b0, 12'd222,  1'b0, 2'd2, 4'b0000, 1'b0};
      tbl[17] = '{1,  4'b0110, P3, 1'b0, 12'd0,    1'b0, 12'd111,  1'b0, 2'd1, 4'b0010, 1'b0};
      tbl[18] = '{7,  4'b0110, P3, 1'b0, 12'd0,    1'b0, 12'd111,  1'b0, 2'd1, 4'b0000, 1'b0};
      tbl[19] = '{3,  4'b0110, P3, 1'b0, 12'd0,    1'b1, 12'd111,  1'b0, 2'd1, 4'b0000, 1'b0};
      tbl[20] = '{1,  4'b0110, P3, 1'b0, 12'd0,    1'b0, 12'd222,  1'b0, 2'd2, 4'b0100, 1'b0};
      tbl[21] = '{2,  4'b0110, P3, 1'b1, 12'd77,   1'b1, 12'd77,   1'b0, 2'd2, 4'b0000, 1'b1};
      tbl[22] = '{3,  4'b0110, P3, 1'b0, 12'd0,    1'b1, 12'd77,   1'b0, 2'd2, 4'b0000, 1'b1};
      tbl[23] = '{1,  4'b0110, P3, 1'b0, 12'd0,    1'b1, 12'd111,  1'b0, 2'd1, 4'b0010, 1'b0};
      tbl[24] = '{2,  4'b0110, P3, 1'b1, 12'd55,   1'b0, 12'd55,   1'b0, 2'd1, 4'b0000, 1'b1};
      tbl[25] = '{1,  4'b0110, P3, 1'b1, 12'd66,   1'b0, 12'd66,   1'b0, 2'd1, 4'b0000, 1'b1};
      tbl[26] = '{4,  4'b0110, P3, 1'b0, 12'd0,    1'b0, 12'd66,   1'b0, 2'd1, 4'b0000, 1'b1};
      tbl[27] = '{1,  4'b0110, P3, 1'b0, 12'd0,    1'b0, 12'd222,  1'b0, 2'd2, 4'b0100, 1'b0};
      tbl[28] = '{7,  4'b0110, P3, 1'b0, 12'd0,    1'b0, 12'd222,  1'b0, 2'd2, 4'b0000, 1'b0};
      tbl[29] = '{1,  4'b0110, P3, 1'b1, 12'd9,    1'b0, 12'd9,    1'b0, 2'd2, 4'b0000, 1'b1};
      tbl[30] = '{5,  4'b0110, P3, 1'b0, 12'd0,    1'b0, 12'd111,  1'b0, 2'd1, 4'b0010, 1'b0};
      tbl[31] = '{3,  4'b0000, P3, 1'b0, 12'd0,    1'b0, 12'd111,  1'b0, 2'd1, 4'b0000, 1'b0};
      tbl[32] = '{5,  4'b0000, P3, 1'b0, 12'd0,    1'b0, 12'd0,    1'b1, 2'd1, 4'b0000, 1'b0};
      tbl[33] = '{3,  4'b0000, P3, 1'b0, 12'd0,    1'b0, 12'd0,    1'b1, 2'd1, 4'b0000, 1'b0};
      tbl[34] = '{1,  4'b0000, P3, 1'b1, 12'd500,  1'b0, 12'd500,  1'b0, 2'd1, 4'b0000, 1'b1};
      tbl[35] = '{5,  4'b0000, P3, 1'b0, 12'd0,    1'b0, 12'd0,    1'b1, 2'd1, 4'b0000, 1'b0};
      tbl[36] = '{1,  4'b0000, P3, 1'b1, 12'd600,  1'b0, 12'd600,  1'b0, 2'd1, 4'b0000, 1'b1};

      bus.src_valid = '0; bus.src_value = '0; bus.alert_req = 1'b0;
      bus.alert_value = '0; bus.freeze = 1'b0;

      // Asynchronous reset, checked before any clock edge.
      #2 rst_n = 1'b0;
      #1 check("reset_async", 12'd0, 1'b1, 2'd0, 4'b0000, 1'b0);
      repeat (3) @(posedge clk);
      #1 check("reset_held", 12'd0, 1'b1, 2'd0, 4'b0000, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      for (int e = 0; e < 37; e++) begin
         bus.src_valid   = tbl[e].valid;
         bus.src_value   = tbl[e].vals;
         bus.alert_value = tbl[e].aval;
         bus.freeze      = tbl[e].frz;
         for (int c = 0; c < tbl[e].n; c++) begin
            bus.alert_req = (c == 0) ? tbl[e].areq : 1'b0;
            @(posedge clk); #1;
         end
         bus.alert_req = 1'b0;
         check($sformatf("vec%0d", e), tbl[e].ev, tbl[e].eb, tbl[e].eid,
               tbl[e].eack, tbl[e].ea);
      end

      // Reset asserted mid-alert takes effect without a clock edge.
      @(posedge clk); #1;
      #2 rst_n = 1'b0;
      #1 check("reset_mid_alert", 12'd0, 1'b1, 2'd0, 4'b0000, 1'b0);
      bus.src_valid = 4'b1111; bus.src_value = P4;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("first_pick_after_reset", 12'd11, 1'b0, 2'd0, 4'b0001, 1'b0);
      // Reset while an ack pulse is on the output cancels it.
      rst_n = 1'b0;
      #1 check("reset_cancels_ack", 12'd0, 1'b1, 2'd0, 4'b0000, 1'b0);
      @(negedge clk) rst_n = 1'b1;

      // ---------------- randomized phase ----------------
      model_reset();
      bus.src_valid = '0; bus.freeze = 1'b0;
      for (int cyc = 0; cyc < 1200; cyc++) begin
         if ($urandom_range(0, 5) == 0) bus.src_valid = 4'($urandom);
         for (int i = 0; i < N_SRC; i++)
            if ($urandom_range(0, 3) == 0) bus.src_value[12*i +: 12] = 12'($urandom);
         bus.alert_req   = ($urandom_range(0, 24) == 0);
         bus.alert_value = 12'($urandom);
         if ($urandom_range(0, 9) == 0) bus.freeze = ~bus.freeze;
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
            #1 model_reset();
            check($sformatf("rnd%0d_reset", cyc), e_val, e_blank, 2'(e_id), e_ack, e_alert);
            @(negedge clk) rst_n = 1'b1;
         end else begin
            @(posedge clk); #1;
            model_step();
            check($sformatf("rnd%0d", cyc), e_val, e_blank, 2'(e_id), e_ack, e_alert);
         end
      end
      bus.alert_req = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Time-shares the 4-digit 7-segment display between up to N_SRC value producers (counters, sensor readouts, debug values).
- Drives the display block's 12-bit value input with round-robin slots of HOLD_CYCLES each.
- A one-shot alert input pre-empts rotation for ALERT_CYCLES.
- Also drives a blank flag and a source-ID indicator (LEDs), and acknowledges each source when its snapshot is taken.

Parameters:
- N_SRC, 4, number of requesting sources (2..8).
- HOLD_CYCLES, 100_000_000, clk cycles per rotation slot (1 s at 100 MHz); must be >= 2.
- ALERT_CYCLES, 200_000_000, clk cycles an alert value is held; must be >= 2.
- CNT_W, 28, slot/alert timer width; must hold max(HOLD_CYCLES, ALERT_CYCLES).
- SEL_W, 2, source index width = clog2(N_SRC), minimum 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- src_valid  input  N_SRC  level; bit i high = source i has a value to show
- src_value  input  12*N_SRC  packed values; source i at [12*i+11:12*i]
- src_ack  output  N_SRC  one-cycle pulse when source i's value is snapshotted
- alert_req  input  1  pulse; request pre-emptive display of alert_value
- alert_value  input  12  value to show during an alert
- freeze  input  1  level; pauses the slot timer (not the alert timer)
- value  output  12  registered value to the display block
- blank  output  1  high = nothing to show; display driver forces all digits off
- src_id  output  SEL_W  index of the source currently shown
- alert_active  output  1  high while the alert is displayed

Behaviour:
- All outputs are registered. Reset (async assert, sync deassert by the clock domain):
  - value=0, blank=1, src_id=0, src_ack=0, alert_active=0.
  - Round-robin pointer last=N_SRC-1, so source 0 has first priority.
  - Timers=0, state=IDLE.
- States: IDLE, SHOW, ALERT.
- Arbitration (the "pick" step): choose the first i with src_valid[i]=1, scanning last+1, last+2, ... modulo N_SRC and including last itself as the final candidate.
  - On a pick: value<=src_value[i], src_id<=i, last<=i, src_ack[i] pulses, timer<=0, blank<=0, next state SHOW.
  - No candidate: blank<=1, value<=0, next state IDLE.
- IDLE:
  - Pick every cycle.
  - If src_valid is seen at cycle t, value, ack and blank=0 appear at t+1.
- SHOW:
  - The timer increments each cycle when freeze=0 and holds when freeze=1.
  - When timer==HOLD_CYCLES-1 with freeze=0, pick. The next value appears on the following edge, so each slot is exactly HOLD_CYCLES cycles.
  - The snapshot is stable for the whole slot, even if src_value or src_valid of the shown source changes mid-slot.
  - A single valid source is re-picked every slot and is acked each time.
- ALERT:
  - Entered from any state on alert_req=1.
  - On entry: value<=alert_value, alert_active<=1, blank<=0, alert timer<=0.
  - src_id and last are unchanged, and no src_ack pulses.
  - After ALERT_CYCLES cycles: alert_active<=0 and pick in the same edge. Rotation resumes after the pre-empted source; no slot time is credited back.
  - freeze does not affect the alert timer.
- Simultaneous events:
  - alert_req in the same cycle as a slot-end pick: the alert wins, with no ack and no pointer advance.
  - alert_req during ALERT: re-latch alert_value and restart the alert timer.
  - freeze in the same cycle as the terminal count: the slot is extended and no pick occurs.
- Reset asserted mid-slot or mid-alert: immediate return to the reset values. Any ack pulse in flight is cancelled.
- Values are passed through unmodified (12 bits, at most 4095, always fits 4 decimal digits). No clamping.

Test Plan:
(Bench uses N_SRC=4, HOLD_CYCLES=8, ALERT_CYCLES=5.)
- Reset with src_valid=4'b0000 -> blank=1, value=0; then set src_valid=4'b0101, src_value[0]=123, src_value[2]=4000 -> next edge value=123, src_id=0, src_ack=4'b0001.
  - After 8 cycles: value=4000, src_id=2, src_ack=4'b0100.
  - After 8 more cycles: back to 123.
- Only source 3 valid, value 999 -> src_ack[3] pulses every 8 cycles and value stays 999. Change src_value[3] to 42 mid-slot -> 42 appears only at the next slot boundary.
- While showing source 1 (sources 1 and 2 valid), pulse alert_req with alert_value=3210 -> next edge value=3210, alert_active=1, src_id=1.
  - After 5 cycles: value=src_value[2], src_id=2, alert_active=0.
- Assert freeze for 20 cycles mid-slot -> value constant; the slot ends 8 unfrozen cycles after its start. Alert during freeze still expires after 5 cycles.
- Drop all src_valid mid-slot -> current value held until slot end, then blank=1, value=0, state IDLE.
- Assert rst_n=0 asynchronously mid-alert -> outputs take reset values without waiting for a clk edge. After release, source 0 is picked first if valid.
